// File: rtl/ping_pong_pkg.sv
// Shared encodings for the ping-pong counter stream checker.
// Direction, error-code and tracker-state constants, plus the per-sample class type.
package ping_pong_pkg;

    // Direction bit carried alongside every counter value
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE          = 2'd0;
    localparam logic [1:0] ERR_STEP          = 2'd1;
    localparam logic [1:0] ERR_RANGE         = 2'd2;
    localparam logic [1:0] ERR_MISSED_BOUNCE = 2'd3;

    // Tracker state encoding
    localparam logic [0:0] ST_SYNC  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    // Verdict for one sample
    typedef enum logic [2:0] {
        CLS_IDLE    = 3'd0,   // no sample this cycle
        CLS_CAPTURE = 3'd1,   // first reference sample while in SYNC
        CLS_HOLD    = 3'd2,   // value and direction unchanged
        CLS_STEP    = 3'd3,   // ordinary step in the current direction
        CLS_BOUNCE  = 3'd4,   // turn taken at the bound being approached
        CLS_FLIP    = 3'd5,   // turn taken away from a bound
        CLS_ERR     = 3'd6    // violation, code carried separately
    } step_class_e;

    // True when a verdict must raise the err pulse
    function automatic logic is_error(input step_class_e cls);
        return (cls == CLS_ERR);
    endfunction

endpackage

// File: rtl/ping_pong_decoder_sat_counter.sv
// Saturating event counter used for the bounce/flip statistics.
// With EN=0 no register is built and the count reads as zero.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter bit EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    generate
        if (EN) begin : g_cnt
            logic [WIDTH-1:0] cnt_q;

            // Count up on each inc, stick at all-ones, clear only on reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
                    cnt_q <= cnt_q + WIDTH'(1);
                end
            end

            assign count = cnt_q;
        end else begin : g_none
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst, inc};
            assign count = '0;
        end
    endgenerate

endmodule

// File: rtl/ping_pong_decoder.sv
// Receive-side checker for a ping-pong counter stream.
// Each strobed (value, direction) sample is judged against the previous one and
// classified as hold / step / bounce / flip or flagged as a violation.
// Optional statistics: define PING_PONG_DECODER_STATS_EN to build the
// saturating bounce/flip counters; otherwise bounce_cnt/flip_cnt read 0.
module ping_pong_decoder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] value,
    input  logic             direction,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    input  logic             err_clear,
    output logic             bounce,
    output logic             flip,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic             locked,
    output logic [CNT_W-1:0] bounce_cnt,
    output logic [CNT_W-1:0] flip_cnt
);

    import ping_pong_pkg::*;

`ifdef PING_PONG_DECODER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    // Reference sample and tracker state
    logic [0:0]       state;
    logic [WIDTH-1:0] prev_val;
    logic             prev_dir;

    // Neighbours of the reference, one bit wider so that 0-1 and max+1
    // never alias onto a legal value (no wrap is ever accepted)
    logic [WIDTH:0]   val_ext;
    logic [WIDTH:0]   prev_inc;
    logic [WIDTH:0]   prev_dec;

    logic             range_ok;
    logic             out_of_range;
    logic             prev_at_bound;
    logic             is_hold;
    logic             step_ok;
    logic             turn_ok;
    logic             missed_bounce;

    step_class_e      cls;
    logic [1:0]       cls_code;

    assign val_ext  = {1'b0, value};
    assign prev_inc = {1'b0, prev_val} + (WIDTH+1)'(1);
    assign prev_dec = {1'b0, prev_val} - (WIDTH+1)'(1);

    // A degenerate window (max <= min) disables the range check entirely
    assign range_ok     = (max > min);
    assign out_of_range = range_ok && ((value > max) || (value < min));

    // Is the reference sitting on the bound it was heading towards?
    assign prev_at_bound = (prev_dir == DIR_UP) ? (prev_val == max) : (prev_val == min);

    assign is_hold = (value == prev_val) && (direction == prev_dir);

    // Same direction, one step along it, and not already at the bound
    assign step_ok = (direction == prev_dir) && !prev_at_bound &&
                     (val_ext == ((prev_dir == DIR_UP) ? prev_inc : prev_dec));

    // Direction changed and the value moved one step in the new direction
    assign turn_ok = (direction != prev_dir) &&
                     (val_ext == ((direction == DIR_UP) ? prev_inc : prev_dec));

    // Kept going in the same direction although the bound was reached
    assign missed_bounce = (direction == prev_dir) && prev_at_bound;

    // Classify the current sample; range violations outrank everything else
    always_comb begin
        cls      = CLS_IDLE;
        cls_code = ERR_NONE;
        if (valid) begin
            if (out_of_range) begin
                cls      = CLS_ERR;
                cls_code = ERR_RANGE;
            end else if (state == ST_SYNC) begin
                cls = CLS_CAPTURE;
            end else if (is_hold) begin
                cls = CLS_HOLD;
            end else if (!range_ok) begin
                cls      = CLS_ERR;
                cls_code = ERR_STEP;
            end else if (step_ok) begin
                cls = CLS_STEP;
            end else if (turn_ok) begin
                cls = prev_at_bound ? CLS_BOUNCE : CLS_FLIP;
            end else if (missed_bounce) begin
                cls      = CLS_ERR;
                cls_code = ERR_MISSED_BOUNCE;
            end else begin
                cls      = CLS_ERR;
                cls_code = ERR_STEP;
            end
        end
    end

    // Every accepted sample (legal or not) becomes the new reference
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_SYNC;
            prev_val <= '0;
            prev_dir <= DIR_UP;
        end else if (valid) begin
            state    <= ST_TRACK;
            prev_val <= value;
            prev_dir <= direction;
        end
    end

    // Register the verdict: pulses, last error code and the sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bounce     <= 1'b0;
            flip       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            err_sticky <= 1'b0;
        end else begin
            bounce     <= (cls == CLS_BOUNCE);
            flip       <= (cls == CLS_FLIP);
            err        <= is_error(cls);
            if (is_error(cls)) begin
                err_code <= cls_code;
            end
            // A fresh error wins over a simultaneous clear
            err_sticky <= (err_sticky && !err_clear) || is_error(cls);
        end
    end

    assign locked = (state == ST_TRACK);

    // Statistics counters advance in the same cycle their pulse is raised
    sat_counter #(.WIDTH(CNT_W), .EN(STATS_EN)) u_bounce_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cls == CLS_BOUNCE),
        .count (bounce_cnt)
    );

    sat_counter #(.WIDTH(CNT_W), .EN(STATS_EN)) u_flip_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cls == CLS_FLIP),
        .count (flip_cnt)
    );

endmodule

// File: tb/tb_ping_pong_decoder.sv
// Scoreboard bench for ping_pong_decoder: directed streams followed by a
// randomized ping-pong stream with injected faults, checked against a
// behavioural reference model of the stream rules.
module tb_ping_pong_decoder;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic [WIDTH-1:0] value;
    logic             direction;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic             err_clear;
    logic             bounce;
    logic             flip;
    logic             err;
    logic [1:0]       err_code;
    logic             err_sticky;
    logic             locked;
    logic [CNT_W-1:0] bounce_cnt;
    logic [CNT_W-1:0] flip_cnt;

    always #5 clk = ~clk;

    ping_pong_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .value      (value),
        .direction  (direction),
        .max        (max),
        .min        (min),
        .err_clear  (err_clear),
        .bounce     (bounce),
        .flip       (flip),
        .err        (err),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .locked     (locked),
        .bounce_cnt (bounce_cnt),
        .flip_cnt   (flip_cnt)
    );

    typedef struct packed {
        logic             bounce;
        logic             flip;
        logic             err;
        logic [1:0]       code;
        logic             sticky;
        logic             locked;
        logic [CNT_W-1:0] bcnt;
        logic [CNT_W-1:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    exp_t m;
    bit   m_ref;
    int   m_p;
    bit   m_d;
    int   b_max;
    int   b_min;

    // Apply the stream rules to the inputs currently on the pins
    task automatic model_apply();
        int v, p, dp, dn, code;
        bit ok, at, b, f, e;
        b = 0; f = 0; code = 0;
        if (rst) begin
            m     = '0;
            m_ref = 0;
            m_p   = 0;
            m_d   = 0;
        end else begin
            if (valid) begin
                v  = int'(value);
                p  = m_p;
                ok = (b_max > b_min);
                if (ok && (v > b_max || v < b_min)) code = 2;
                else if (!m_ref) code = 0;
                else if (v == p && direction == m_d) code = 0;
                else if (!ok) code = 1;
                else begin
                    dp = m_d ? -1 : 1;
                    dn = direction ? -1 : 1;
                    at = m_d ? (p == b_min) : (p == b_max);
                    if (direction == m_d) code = at ? 3 : ((v == p + dp) ? 0 : 1);
                    else if (v == p + dn) begin
                        if (at) b = 1; else f = 1;
                    end else code = 1;
                end
                m_ref = 1;
                m_p   = v;
                m_d   = direction;
            end
            e = (code != 0);
            m.bounce = b;
            m.flip   = f;
            m.err    = e;
            if (e) m.code = code[1:0];
            m.sticky = (m.sticky && !err_clear) || e;
            m.locked = m_ref;
`ifdef PING_PONG_DECODER_STATS_EN
            if (b && m.bcnt != {CNT_W{1'b1}}) m.bcnt = m.bcnt + 1'b1;
            if (f && m.fcnt != {CNT_W{1'b1}}) m.fcnt = m.fcnt + 1'b1;
`endif
        end
    endtask

    // Drive one cycle of stimulus and queue the response it must produce
    task automatic drive(input bit r, input bit vl, input int v, input bit dir, input bit clr);
        @(negedge clk);
        rst       = r;
        valid     = vl;
        value     = v[WIDTH-1:0];
        direction = dir;
        err_clear = clr;
        max       = b_max[WIDTH-1:0];
        min       = b_min[WIDTH-1:0];
        model_apply();
        exp_q.push_back(m);
    endtask

    task automatic smp(input int v, input bit dir);
        drive(1'b0, 1'b1, v, dir, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit clr);
        drive(1'b0, 1'b0, 0, 1'b0, clr);
    endtask

    // Monitor: compare every queued expectation with the DUT outputs
    initial begin : monitor
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g.bounce = bounce;
                g.flip   = flip;
                g.err    = err;
                g.code   = err_code;
                g.sticky = err_sticky;
                g.locked = locked;
                g.bcnt   = bounce_cnt;
                g.fcnt   = flip_cnt;
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL scoreboard @%0t got b%0b f%0b e%0b c%0d s%0b l%0b bc%0d fc%0d, want b%0b f%0b e%0b c%0d s%0b l%0b bc%0d fc%0d",
                             $time, g.bounce, g.flip, g.err, g.code, g.sticky, g.locked, g.bcnt, g.fcnt,
                             e.bounce, e.flip, e.err, e.code, e.sticky, e.locked, e.bcnt, e.fcnt);
                end
            end
        end
    end

    // Stimulus: directed streams, then a randomized ping-pong stream
    initial begin : stim
        int gv, nv, sel, r;
        bit gd, nd;
        rst = 1'b1; valid = 1'b0; value = '0; direction = 1'b0; err_clear = 1'b0;
        b_max = 5; b_min = 1;
        max = 4'd5; min = 4'd1;
        m = '0; m_ref = 0; m_p = 0; m_d = 0;

        // Full sweep up to the bound and back: one bounce
        do_reset();
        smp(1, 0); smp(2, 0); smp(3, 0); smp(4, 0); smp(5, 0); smp(4, 1); smp(3, 1);
        idle(0);
        // Turn away from the bound: flip, then holds
        do_reset();
        smp(3, 0); smp(2, 1); smp(2, 1); smp(2, 1);
        // Out of range, sticky error and its clear
        do_reset();
        smp(4, 0); smp(5, 0); smp(6, 0); idle(0); idle(1); idle(0);
        // Full-scale window: wrap is a missed bounce
        b_max = 15; b_min = 0;
        do_reset();
        smp(14, 0); smp(15, 0); smp(0, 0); smp(15, 1);
        // Skipped value, resync, then reset mid-stream
        b_max = 5; b_min = 1;
        do_reset();
        smp(2, 0); smp(4, 0); smp(5, 0); do_reset(); idle(0);
        // Degenerate window: only holds are legal, no range error
        b_max = 3; b_min = 3;
        do_reset();
        smp(3, 0); smp(3, 0); smp(4, 0); smp(4, 1);
        // Error and clear in the same cycle keep the sticky flag
        b_max = 5; b_min = 1;
        do_reset();
        smp(2, 0); drive(1'b0, 1'b1, 9, 1'b0, 1'b1); idle(0);

        // Randomized stream
        b_max = 12; b_min = 2;
        gv = 2; gd = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99, 0) == 0) begin
                b_min = $urandom_range(10, 0);
                if ($urandom_range(6, 0) == 0) b_max = $urandom_range(b_min, 0);
                else b_max = b_min + $urandom_range(5, 1);
            end
            r = $urandom_range(999, 0);
            if (r < 3) begin
                do_reset();
            end else if ($urandom_range(9, 0) < 2) begin
                idle($urandom_range(29, 0) == 0);
            end else begin
                sel = $urandom_range(99, 0);
                if (gd == 0) begin
                    if (gv >= b_max) begin nd = 1; nv = gv - 1; end
                    else begin nd = 0; nv = gv + 1; end
                end else begin
                    if (gv <= b_min) begin nd = 0; nv = gv + 1; end
                    else begin nd = 1; nv = gv - 1; end
                end
                if (sel < 10) begin
                    nv = gv; nd = gd;
                end else if (sel < 16) begin
                    nd = ~gd; nv = gd ? gv + 1 : gv - 1;
                end else if (sel < 19) begin
                    nd = gd; nv = gd ? gv - 1 : gv + 1;
                end else if (sel < 24) begin
                    nv = $urandom_range(15, 0); nd = $urandom_range(1, 0);
                end
                if (nv < 0) nv = 0;
                if (nv > 15) nv = 15;
                drive(1'b0, 1'b1, nv, nd, $urandom_range(29, 0) == 0);
                gv = nv; gd = nd;
            end
        end

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
